// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - OF-out operand, writeback-source and forward/stall bundle for fwd_hazard_unit
interface fwd_hazard_unit_if #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 3
);
    logic                       of_valid;
    logic [REG_AW-1:0]          of_rs1;
    logic [REG_AW-1:0]          of_rs2;
    logic                       of_rs1_used;
    logic                       of_rs2_used;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC-1:0]         src_wb_en;
    logic [NUM_SRC*REG_AW-1:0]  src_rd;
    logic [NUM_SRC*XLEN-1:0]    src_data;
    logic [NUM_SRC-1:0]         src_data_rdy;
    logic                       flush;

    logic                       fwd_rs1_en;
    logic [XLEN-1:0]            fwd_rs1_data;
    logic                       fwd_rs2_en;
    logic [XLEN-1:0]            fwd_rs2_data;
    logic                       stall_if;
    logic                       stall_ifof;
    logic                       stall_ofex;
    logic                       stall_exmem;
    logic                       stall_memwb;
    logic                       bubble_ofex;

    modport master (
        output of_valid, of_rs1, of_rs2, of_rs1_used, of_rs2_used,
        output src_valid, src_wb_en, src_rd, src_data, src_data_rdy, flush,
        input  fwd_rs1_en, fwd_rs1_data, fwd_rs2_en, fwd_rs2_data,
        input  stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb, bubble_ofex
    );

    modport slave (
        input  of_valid, of_rs1, of_rs2, of_rs1_used, of_rs2_used,
        input  src_valid, src_wb_en, src_rd, src_data, src_data_rdy, flush,
        output fwd_rs1_en, fwd_rs1_data, fwd_rs2_en, fwd_rs2_data,
        output stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb, bubble_ofex
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - RAW forwarding select and load-use stall FSM; FWD_HAZARD_STATS_EN adds event counters
module fwd_hazard_unit #(
    parameter int XLEN              = 32,
    parameter int REG_AW            = 5,
    parameter int NUM_SRC           = 3,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic               clk,
    input  logic               resetn,
    fwd_hazard_unit_if.slave   bus
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]        fwd_event_cnt,
    output logic [31:0]        stall_cycle_cnt
`endif
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam logic [2:0] LOAD_CNT = 3'(LOAD_STALL_CYCLES - 1);

    logic [0:0]         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               en1_q, en1_d, en2_q, en2_d;
    logic [XLEN-1:0]    data1_q, data1_d, data2_q, data2_d;

    logic [NUM_SRC-1:0] hit1, hit2;
    logic               any1, rdy1, any2, rdy2;
    logic [XLEN-1:0]    sel1, sel2;
    logic               hazard, stalling;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_hit
        logic [REG_AW-1:0] rd;
        logic              wr;
        assign rd = bus.src_rd[g*REG_AW +: REG_AW];
        assign wr = bus.of_valid & bus.src_valid[g] & bus.src_wb_en[g];
        assign hit1[g] = wr & bus.of_rs1_used & (rd == bus.of_rs1) & (bus.of_rs1 != '0);
        assign hit2[g] = wr & bus.of_rs2_used & (rd == bus.of_rs2) & (bus.of_rs2 != '0);
    end

    // Walk oldest to youngest so the lowest hitting index overwrites the rest.
    always_comb begin
        any1 = 1'b0;
        rdy1 = 1'b0;
        sel1 = '0;
        any2 = 1'b0;
        rdy2 = 1'b0;
        sel2 = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hit1[i]) begin
                any1 = 1'b1;
                rdy1 = bus.src_data_rdy[i];
                sel1 = bus.src_data[i*XLEN +: XLEN];
            end
            if (hit2[i]) begin
                any2 = 1'b1;
                rdy2 = bus.src_data_rdy[i];
                sel2 = bus.src_data[i*XLEN +: XLEN];
            end
        end
    end

    assign hazard   = (any1 & ~rdy1) | (any2 & ~rdy2);
    assign stalling = resetn & ~bus.flush & ((state_q == ST_STALL) | hazard);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (hazard) begin
                state_d = ST_STALL;
                cnt_d   = LOAD_CNT;
            end
        end else if (cnt_q == '0) begin
            state_d = ST_RUN;
        end else begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    assign en1_d   = any1 & rdy1 & ~stalling & ~bus.flush;
    assign en2_d   = any2 & rdy2 & ~stalling & ~bus.flush;
    assign data1_d = en1_d ? sel1 : data1_q;
    assign data2_d = en2_d ? sel2 : data2_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign bus.fwd_rs1_en   = en1_q;
    assign bus.fwd_rs1_data = data1_q;
    assign bus.fwd_rs2_en   = en2_q;
    assign bus.fwd_rs2_data = data2_q;
    assign bus.stall_if     = stalling;
    assign bus.stall_ifof   = stalling;
    assign bus.bubble_ofex  = stalling;
    assign bus.stall_ofex   = 1'b0;
    assign bus.stall_exmem  = 1'b0;
    assign bus.stall_memwb  = 1'b0;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] ev_q, ev_d, sc_q, sc_d;
    logic [32:0] ev_sum, sc_sum;

    assign ev_sum = {1'b0, ev_q} + {31'd0, en1_d} + {31'd0, en2_d};
    assign sc_sum = {1'b0, sc_q} + {32'd0, stalling};
    assign ev_d   = ev_sum[32] ? 32'hFFFF_FFFF : ev_sum[31:0];
    assign sc_d   = sc_sum[32] ? 32'hFFFF_FFFF : sc_sum[31:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ev_q <= '0;
            sc_q <= '0;
        end else begin
            ev_q <= ev_d;
            sc_q <= sc_d;
        end
    end

    assign fwd_event_cnt   = ev_q;
    assign stall_cycle_cnt = sc_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed vector bench for fwd_hazard_unit (LOAD_STALL_CYCLES 2 and 3 instances)
module tb_fwd_hazard_unit;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NS   = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic            of_valid, u1, u2, flush;
    logic [AW-1:0]   rs1, rs2, rd0, rd1, rd2;
    logic [NS-1:0]   sv, we, rdy;
    logic [XLEN-1:0] d0, d1, d2;

    fwd_hazard_unit_if #(.XLEN(XLEN), .REG_AW(AW), .NUM_SRC(NS)) if2 ();
    fwd_hazard_unit_if #(.XLEN(XLEN), .REG_AW(AW), .NUM_SRC(NS)) if3 ();

    assign if2.of_valid = of_valid;      assign if3.of_valid = of_valid;
    assign if2.of_rs1 = rs1;             assign if3.of_rs1 = rs1;
    assign if2.of_rs2 = rs2;             assign if3.of_rs2 = rs2;
    assign if2.of_rs1_used = u1;         assign if3.of_rs1_used = u1;
    assign if2.of_rs2_used = u2;         assign if3.of_rs2_used = u2;
    assign if2.src_valid = sv;           assign if3.src_valid = sv;
    assign if2.src_wb_en = we;           assign if3.src_wb_en = we;
    assign if2.src_rd = {rd2, rd1, rd0}; assign if3.src_rd = {rd2, rd1, rd0};
    assign if2.src_data = {d2, d1, d0};  assign if3.src_data = {d2, d1, d0};
    assign if2.src_data_rdy = rdy;       assign if3.src_data_rdy = rdy;
    assign if2.flush = flush;            assign if3.flush = flush;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] ev2, sc2, ev3, sc3;
`endif

    fwd_hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL_CYCLES(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .bus(if2)
`ifdef FWD_HAZARD_STATS_EN
        , .fwd_event_cnt(ev2), .stall_cycle_cnt(sc2)
`endif
    );

    fwd_hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .bus(if3)
`ifdef FWD_HAZARD_STATS_EN
        , .fwd_event_cnt(ev3), .stall_cycle_cnt(sc3)
`endif
    );

    typedef struct packed {
        logic            ofv;
        logic [AW-1:0]   rs1, rs2;
        logic            u1, u2;
        logic [NS-1:0]   sv, we;
        logic [AW-1:0]   rd0, rd1, rd2;
        logic [XLEN-1:0] d0, d1, d2;
        logic [NS-1:0]   rdy;
        logic            e_stall;
        logic            e_en1;
        logic [XLEN-1:0] e_d1;
        logic            e_en2;
        logic [XLEN-1:0] e_d2;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] st2();
        return {if2.stall_if, if2.stall_ifof, if2.bubble_ofex, if2.stall_ofex, if2.stall_exmem, if2.stall_memwb};
    endfunction

    function automatic logic [5:0] st3();
        return {if3.stall_if, if3.stall_ifof, if3.bubble_ofex, if3.stall_ofex, if3.stall_exmem, if3.stall_memwb};
    endfunction

    task automatic idle();
        of_valid = 0; u1 = 0; u2 = 0; flush = 0;
        rs1 = 0; rs2 = 0; rd0 = 0; rd1 = 0; rd2 = 0;
        sv = 0; we = 0; rdy = 3'b111; d0 = 0; d1 = 0; d2 = 0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        @(posedge clk); #1;
        resetn = 1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1, 5,  0,  1, 0, 3'b001, 3'b001, 5,  0,  0,  32'hDEAD_BEEF, 0, 0,  3'b111, 0, 1, 32'hDEAD_BEEF, 0, 0};
        vecs[1]  = '{1, 7,  7,  1, 1, 3'b101, 3'b101, 7,  0,  7,  1, 0, 3,           3'b111, 0, 1, 1,    1, 1};
        vecs[2]  = '{1, 7,  7,  1, 1, 3'b100, 3'b100, 7,  0,  7,  1, 0, 3,           3'b111, 0, 1, 3,    1, 3};
        vecs[3]  = '{1, 0,  0,  1, 0, 3'b001, 3'b001, 0,  0,  0,  32'h55, 0, 0,      3'b111, 0, 0, 3,    0, 3};
        vecs[4]  = '{1, 1,  3,  1, 0, 3'b001, 3'b001, 3,  0,  0,  32'h33, 0, 0,      3'b111, 0, 0, 3,    0, 3};
        vecs[5]  = '{1, 4,  0,  1, 0, 3'b001, 3'b000, 4,  0,  0,  32'h44, 0, 0,      3'b111, 0, 0, 3,    0, 3};
        vecs[6]  = '{0, 4,  4,  1, 1, 3'b001, 3'b001, 4,  0,  0,  32'h44, 0, 0,      3'b111, 0, 0, 3,    0, 3};
        vecs[7]  = '{1, 11, 10, 1, 1, 3'b011, 3'b011, 10, 11, 0,  32'hA, 32'hB, 0,   3'b111, 0, 1, 32'hB, 1, 32'hA};
        vecs[8]  = '{1, 12, 12, 1, 0, 3'b111, 3'b111, 20, 12, 12, 0, 32'h12, 32'h22, 3'b110, 0, 1, 32'h12, 0, 32'hA};
        vecs[9]  = '{1, 12, 0,  1, 0, 3'b000, 3'b111, 12, 12, 12, 1, 2, 3,           3'b111, 0, 0, 32'h12, 0, 32'hA};
        vecs[10] = '{1, 0,  9,  0, 0, 3'b001, 3'b001, 9,  0,  0,  32'h99, 0, 0,      3'b110, 0, 0, 32'h12, 0, 32'hA};
        vecs[11] = '{1, 0,  0,  1, 1, 3'b001, 3'b001, 0,  0,  0,  5, 0, 0,           3'b110, 0, 0, 32'h12, 0, 32'hA};

        // Reset with a live load-use pattern on the inputs: stalls must stay low.
        idle();
        resetn = 0;
        of_valid = 1; rs2 = 9; u2 = 1; sv = 3'b001; we = 3'b001; rd0 = 9; rdy = 3'b110;
        #1;
        chk("reset_stall2", 32'(st2()), 0);
        chk("reset_stall3", 32'(st3()), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_en", {28'd0, if2.fwd_rs1_en, if2.fwd_rs2_en, if3.fwd_rs1_en, if3.fwd_rs2_en}, 0);
        chk("reset_d1", if2.fwd_rs1_data, 0);
        chk("reset_d2", if2.fwd_rs2_data, 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("reset_stats", ev2 | sc2, 0);
`endif
        idle();
        resetn = 1;

        for (int k = 0; k < 12; k++) begin
            of_valid = vecs[k].ofv; rs1 = vecs[k].rs1; rs2 = vecs[k].rs2;
            u1 = vecs[k].u1; u2 = vecs[k].u2; sv = vecs[k].sv; we = vecs[k].we;
            rd0 = vecs[k].rd0; rd1 = vecs[k].rd1; rd2 = vecs[k].rd2;
            d0 = vecs[k].d0; d1 = vecs[k].d1; d2 = vecs[k].d2; rdy = vecs[k].rdy;
            #1;
            chk($sformatf("v%0d_stall", k), 32'(st2()), vecs[k].e_stall ? 32'h38 : 32'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_en1", k), 32'(if2.fwd_rs1_en), 32'(vecs[k].e_en1));
            chk($sformatf("v%0d_d1", k), if2.fwd_rs1_data, vecs[k].e_d1);
            chk($sformatf("v%0d_en2", k), 32'(if2.fwd_rs2_en), 32'(vecs[k].e_en2));
            chk($sformatf("v%0d_d2", k), if2.fwd_rs2_data, vecs[k].e_d2);
        end

        // Load-use on rs2 with two bubbles: detect cycle plus two STALL cycles.
        do_reset();
        of_valid = 1; rs2 = 9; u2 = 1; sv = 3'b001; we = 3'b001; rd0 = 9; rdy = 3'b110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lu_stall%0d", k), 32'(st2()), 32'h38);
            @(posedge clk); #1;
            chk($sformatf("lu_en2_%0d", k), 32'(if2.fwd_rs2_en), 0);
        end
        sv = 3'b010; we = 3'b010; rd0 = 0; rd1 = 9; d1 = 32'h99; rdy = 3'b111;
        #1;
        chk("lu_release", 32'(st2()), 0);
        @(posedge clk); #1;
        chk("lu_en2", 32'(if2.fwd_rs2_en), 1);
        chk("lu_d2", if2.fwd_rs2_data, 32'h99);

        // Flush during the first STALL cycle of the three-bubble instance.
        do_reset();
        of_valid = 1; rs1 = 5; u1 = 1; rs2 = 9; u2 = 1;
        sv = 3'b011; we = 3'b011; rd0 = 9; rd1 = 5; d0 = 32'h77; d1 = 32'h55; rdy = 3'b110;
        #1;
        chk("fl_detect", 32'(st3()), 32'h38);
        @(posedge clk); #1;
        chk("fl_en1_stall", 32'(if3.fwd_rs1_en), 0);
        chk("fl_in_stall", 32'(st3()), 32'h38);
        flush = 1;
        #1;
        chk("fl_drop", 32'(st3()), 0);
        @(posedge clk); #1;
        chk("fl_en", {30'd0, if3.fwd_rs1_en, if3.fwd_rs2_en}, 0);
        flush = 0;
        rdy = 3'b111;
        #1;
        chk("fl_run", 32'(st3()), 0);
        @(posedge clk); #1;
        chk("fl_en_after", {30'd0, if3.fwd_rs1_en, if3.fwd_rs2_en}, 3);
        chk("fl_d1", if3.fwd_rs1_data, 32'h55);
        chk("fl_d2", if3.fwd_rs2_data, 32'h77);

        // Reset in the middle of a stall aborts it and clears the forward registers.
        of_valid = 1; rs1 = 0; u1 = 0; rs2 = 9; u2 = 1;
        sv = 3'b001; we = 3'b001; rd0 = 9; rdy = 3'b110;
        #1;
        chk("rs_detect", 32'(st3()), 32'h38);
        @(posedge clk); #1;
        chk("rs_in_stall", 32'(st3()), 32'h38);
        resetn = 0;
        #1;
        chk("rs_stall_low", 32'(st3()), 0);
        @(posedge clk); #1;
        resetn = 1;
        idle();
        chk("rs_en", {30'd0, if3.fwd_rs1_en, if3.fwd_rs2_en}, 0);
        chk("rs_data", if3.fwd_rs1_data | if3.fwd_rs2_data, 0);
        #1;
        chk("rs_run", 32'(st3()), 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("rs_ev", ev3, 0);
        chk("rs_sc", sc3, 0);
`endif
        of_valid = 1; rs1 = 5; u1 = 1; sv = 3'b001; we = 3'b001; rd0 = 5; d0 = 32'hC0FFEE; rdy = 3'b111;
        @(posedge clk); #1;
        chk("rs_hit_en1", 32'(if3.fwd_rs1_en), 1);
        chk("rs_hit_d1", if3.fwd_rs1_data, 32'hC0FFEE);
`ifdef FWD_HAZARD_STATS_EN
        chk("rs_ev1", ev3, 1);
        chk("rs_sc0", sc3, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
